// File: rtl/pca_proj_pkg.sv
// Shared defaults, FSM state type and fixed-point helpers for the PCA projection MAC array.
package pca_proj_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int FRAC_W_DEF     = 8;
    localparam int PC_NUM_DEF     = 32;
    localparam int MAJ_PC_NUM_DEF = 10;
    localparam int OUT_W_DEF      = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Wide enough to sum pc_num full-precision products without overflow.
    function automatic int acc_width(input int data_w, input int pc_num);
        return 2 * data_w + $clog2(pc_num);
    endfunction

    // Round half up by dropping frac_w bits, then clamp to a signed out_w range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int frac_w,
                                                     input int out_w,
                                                     output logic sat);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r   = (frac_w > 0) ? ((acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w) : acc;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pca_mac_lane.sv
// One projection lane: signed MAC into a wide accumulator plus round/saturate output register.
// Latency: result registered on the cycle the last beat is accepted.
// Backpressure: none locally; the shared FSM gates acc_en/out_load.
module pca_mac_lane
    import pca_proj_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ACC_W  = acc_width(DATA_W_DEF, PC_NUM_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_clr,
    input  logic              acc_en,
    input  logic              lane_en,
    input  logic              out_load,
    input  logic [DATA_W-1:0] feat,
    input  logic [DATA_W-1:0] coef,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_base;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [63:0]         rs;
    logic                       rs_sat;
    logic                       unused_rs_hi;

    always_comb begin
        prod     = (2*DATA_W)'($signed(feat)) * (2*DATA_W)'($signed(coef));
        acc_base = acc_clr ? '0 : acc;
        acc_next = lane_en ? acc_base + ACC_W'(prod) : acc_base;
        rs_sat   = 1'b0;
        rs       = round_sat(64'(acc_next), FRAC_W, OUT_W, rs_sat);
    end

    assign unused_rs_hi = ^rs[63:OUT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (acc_en) acc <= acc_next;
            // Convert the post-beat sum so the result lands together with out_valid.
            if (out_load) begin
                out_data <= rs[OUT_W-1:0];
                out_sat  <= rs_sat;
            end
        end
    end

endmodule

// File: rtl/pca_proj_mac_array.sv
// Projects a PC_NUM-beat feature vector onto up to MAJ_PC_NUM component vectors in parallel.
// Latency: out_valid one cycle after the last accepted beat.
// Backpressure: in_ready low while a result waits in HOLD for out_ready.
module pca_proj_mac_array
    import pca_proj_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF,
    parameter int PC_NUM     = PC_NUM_DEF,
    parameter int MAJ_PC_NUM = MAJ_PC_NUM_DEF,
    parameter int OUT_W      = OUT_W_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_feat,
    input  logic [MAJ_PC_NUM*DATA_W-1:0]       in_coef,
    input  logic [$clog2(MAJ_PC_NUM+1)-1:0]    num_active,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [MAJ_PC_NUM*OUT_W-1:0]        out_data,
    output logic [MAJ_PC_NUM-1:0]              out_sat
);

    localparam int ACC_W = acc_width(DATA_W, PC_NUM);
    localparam int NA_W  = $clog2(MAJ_PC_NUM + 1);
    localparam int CNT_W = $clog2(PC_NUM + 1);

    state_t                  state;
    logic [CNT_W-1:0]        beat_cnt;
    logic [NA_W-1:0]         act_num;
    logic [NA_W-1:0]         na_clamp;
    logic [NA_W-1:0]         eff_num;
    logic [MAJ_PC_NUM-1:0]   lane_en;
    logic                    beat;
    logic                    first;
    logic                    last;

    assign beat     = in_valid && in_ready;
    assign first    = (state == IDLE);
    assign na_clamp = (num_active > NA_W'(MAJ_PC_NUM)) ? NA_W'(MAJ_PC_NUM) : num_active;
    // On the first beat the lane mask comes straight from the port, afterwards from the latch.
    assign eff_num  = first ? na_clamp : act_num;
    assign last     = beat && (first ? (PC_NUM == 1) : (beat_cnt == CNT_W'(PC_NUM - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            act_num   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        if (state == IDLE) begin
                            act_num  <= na_clamp;
                            beat_cnt <= CNT_W'(1);
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                        if (last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        beat_cnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < MAJ_PC_NUM; k++) begin : g_lane
        assign lane_en[k] = (NA_W'(k) < eff_num);

        pca_mac_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .OUT_W  (OUT_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .acc_clr  (first),
            .acc_en   (beat),
            .lane_en  (lane_en[k]),
            .out_load (last),
            .feat     (in_feat),
            .coef     (in_coef[k*DATA_W +: DATA_W]),
            .out_data (out_data[k*OUT_W +: OUT_W]),
            .out_sat  (out_sat[k])
        );
    end

endmodule

// File: tb/tb_pca_proj_mac_array.sv
// Scoreboard bench for pca_proj_mac_array with a small 4-beat, 2-lane configuration.
module tb_pca_proj_mac_array;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int PC_NUM = 4;
    localparam int MAJ    = 2;
    localparam int OUT_W  = 24;

    typedef struct {
        int       d0;
        int       d1;
        bit [1:0] sat;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_feat;
    logic [MAJ*DATA_W-1:0] in_coef;
    logic [1:0]          num_active;
    logic                out_valid;
    logic                out_ready;
    logic [MAJ*OUT_W-1:0] out_data;
    logic [MAJ-1:0]      out_sat;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   beats_seen = 0;
    bit   prev_ov = 0;
    bit   prev_rdy = 0;
    logic [MAJ*OUT_W-1:0] prev_data;
    logic [MAJ-1:0]       prev_sat;

    pca_proj_mac_array #(
        .DATA_W     (DATA_W),
        .FRAC_W     (FRAC_W),
        .PC_NUM     (PC_NUM),
        .MAJ_PC_NUM (MAJ),
        .OUT_W      (OUT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_feat    (in_feat),
        .in_coef    (in_coef),
        .num_active (num_active),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor: latency, HOLD stability, in_ready in HOLD, and scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        longint a0, a1;
        cyc++;
        if (reset) begin
            beats_seen = 0;
            prev_ov    = 0;
        end else begin
            if (in_valid && in_ready) begin
                beats_seen++;
                if (beats_seen == PC_NUM) begin
                    last_cyc   = cyc;
                    beats_seen = 0;
                end
            end
            if (out_valid) begin
                check("hold_in_ready", in_ready == 1'b0, in_ready, 0);
                if (!prev_ov)
                    check("latency", (cyc - last_cyc) == 1, cyc - last_cyc, 1);
                else if (!prev_rdy)
                    check("hold_stable", out_data == prev_data && out_sat == prev_sat,
                          out_data, prev_data);
                if (out_ready) begin
                    check("scoreboard_nonempty", q.size() > 0, q.size(), 1);
                    if (q.size() > 0) begin
                        e  = q.pop_front();
                        a0 = $signed(out_data[0 +: OUT_W]);
                        a1 = $signed(out_data[OUT_W +: OUT_W]);
                        check("lane0_data", a0 == e.d0, a0, e.d0);
                        check("lane1_data", a1 == e.d1, a1, e.d1);
                        check("out_sat", out_sat == e.sat, out_sat, e.sat);
                    end
                end
            end
            prev_ov   = out_valid;
            prev_rdy  = out_ready;
            prev_data = out_data;
            prev_sat  = out_sat;
        end
    end

    task automatic send_beat(input logic [DATA_W-1:0] f, input logic [DATA_W-1:0] c0,
                             input logic [DATA_W-1:0] c1, input logic [1:0] na);
        bit rdy;
        int n;
        n          = 0;
        in_valid   = 1'b1;
        in_feat    = f;
        in_coef    = {c1, c0};
        num_active = na;
        do begin
            @(negedge clk);
            rdy = in_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!rdy && n < 100);
        if (!rdy) check("beat_accept", rdy, 0, 1);
        in_valid   = 1'b0;
        in_feat    = DATA_W'($urandom);
        in_coef    = {DATA_W'($urandom), DATA_W'($urandom)};
        num_active = 2'($urandom);
    endtask

    // single=1: only beat 0 carries data, later beats are zero.
    task automatic send_vec(input logic [DATA_W-1:0] f, input logic [DATA_W-1:0] c0,
                            input logic [DATA_W-1:0] c1, input logic [1:0] na,
                            input bit single, input bit gaps, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (single && b > 0) send_beat('0, '0, '0, na);
            else                 send_beat(f, c0, c1, na);
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic expect_res(input int d0, input int d1, input bit [1:0] sat);
        exp_t e;
        e.d0  = d0;
        e.d1  = d1;
        e.sat = sat;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", q.size() == 0, q.size(), 0);
    endtask

    initial begin
        bit seen;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_feat    = '0;
        in_coef    = '0;
        num_active = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
        check("rst_out_data", out_data == '0, out_data, 0);
        check("rst_out_sat", out_sat == '0, out_sat, 0);
        @(posedge clk);
        #1;

        // 1.0*1.0*4 = 4.0 -> 1024; 1.0*-0.5*4 = -2.0 -> -512
        expect_res(1024, -512, 2'b00);
        send_vec(16'd256, 16'd256, -16'sd128, 2'd2, 0, 0, PC_NUM);
        drain();

        // Gaps on the input and a 5-cycle stall on the output.
        out_ready = 1'b0;
        expect_res(1024, -512, 2'b00);
        send_vec(16'd256, 16'd256, -16'sd128, 2'd2, 0, 1, PC_NUM);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check("stall_out_valid", out_valid == 1'b1, out_valid, 1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Positive clamp on lane 0 only.
        expect_res(8388607, 0, 2'b01);
        send_vec(16'd32767, 16'd32767, 16'd0, 2'd2, 0, 0, PC_NUM);
        drain();

        // Both directions clamp: (-1)*(-1)*2^30*4 high, -2^15*32767*4 low.
        expect_res(8388607, -8388608, 2'b11);
        send_vec(16'h8000, 16'h8000, 16'd32767, 2'd2, 0, 0, PC_NUM);
        drain();

        // 128/256 rounds up to 1; -129/256 = -0.504 rounds to -1.
        expect_res(1, -1, 2'b00);
        send_vec(16'd1, 16'd128, -16'sd129, 2'd2, 1, 0, PC_NUM);
        drain();

        expect_res(1024, 0, 2'b00);
        send_vec(16'd256, 16'd256, -16'sd128, 2'd1, 0, 0, PC_NUM);
        drain();

        expect_res(0, 0, 2'b00);
        send_vec(16'd256, 16'd256, -16'sd128, 2'd0, 0, 0, PC_NUM);
        drain();

        // num_active above the lane count behaves as all lanes.
        expect_res(1024, -512, 2'b00);
        send_vec(16'd256, 16'd256, -16'sd128, 2'd3, 0, 0, PC_NUM);
        drain();

        // Abort a vector after two beats.
        send_vec(16'd256, 16'd256, -16'sd128, 2'd2, 0, 0, 2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("no_valid_after_reset", !seen, seen, 0);
        @(posedge clk);
        #1;

        expect_res(1024, -512, 2'b00);
        send_vec(16'd256, 16'd256, -16'sd128, 2'd2, 0, 0, PC_NUM);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
